// File: rtl/transpose_rtype_cfg.sv
// Custom-instruction matrix accelerator: loads A, transposes or copies
// it into B one element per cycle, and returns status/B reads via rd.
module transpose_rtype_cfg #(
   parameter int MAX_M  = 8,
   parameter int MAX_N  = 8,
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [4:0]  rd_addr,
   output logic        rd_we,
   output logic [4:0]  rd_waddr,
   output logic [31:0] rd_wdata,
   output logic        accel_busy,
   output logic        accel_done,
   output logic        accel_err
);
   localparam int BD = (MAX_M > MAX_N) ? MAX_M : MAX_N;
   localparam int AN = MAX_M * MAX_N;
   localparam int BN = BD * BD;
   localparam int AW = (AN > 1) ? $clog2(AN) : 1;
   localparam int BW = (BN > 1) ? $clog2(BN) : 1;
   localparam logic [15:0] RMAX = 16'(MAX_M);
   localparam logic [15:0] CMAX = 16'(MAX_N);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state;
   logic              rdy, done, err, fin, md;
   logic              brd_p1, brd_oob;
   logic [15:0]       rows, cols, ci, cj;
   logic [DATA_W-1:0] bq;
   logic [DATA_W-1:0] a_mem [AN];
   logic [DATA_W-1:0] b_mem [BN];

   logic        acc, legal, idle, busy;
   logic        op_awr, op_start, op_stat, op_brd;
   logic        op_cfg, op_abort, op_bad;
   logic [15:0] hi, lo;
   logic        cfg_bad, awr_oob, brd_oob_c, last;
   logic        new_err, a_we, b_we;
   logic [AW-1:0] a_idx, e_a;
   logic [BW-1:0] e_b, r_idx;
   logic        unused_bits;

   assign unused_bits = ^{instr[24:15], instr[11:7], rs2_val};

   always_comb begin
      acc      = instr_valid & rdy;
      idle     = (state == IDLE);
      busy     = ~idle;
      hi       = rs1_val[31:16];
      lo       = rs1_val[15:0];
      legal    = (instr[6:0] == 7'h33) && (instr[31:25] == 7'h02);
      op_awr   = 1'b0;
      op_start = 1'b0;
      op_stat  = 1'b0;
      op_brd   = 1'b0;
      op_cfg   = 1'b0;
      op_abort = 1'b0;
      op_bad   = 1'b0;
      if (acc) begin
         if (!legal) op_bad = 1'b1;
         else begin
            unique case (instr[14:12])
               3'd0:    op_awr   = 1'b1;
               3'd1:    op_start = 1'b1;
               3'd2:    op_stat  = 1'b1;
               3'd3:    op_brd   = 1'b1;
               3'd4:    op_cfg   = 1'b1;
               3'd5:    op_abort = 1'b1;
               default: op_bad   = 1'b1;
            endcase
         end
      end
      cfg_bad   = (hi == 16'd0) || (lo == 16'd0) || (hi > RMAX) || (lo > CMAX);
      awr_oob   = (hi >= rows) || (lo >= cols);
      // B is C x R when transposing, R x C when copying
      brd_oob_c = md ? awr_oob : ((hi >= cols) || (lo >= rows));
      last      = (ci == rows - 16'd1) && (cj == cols - 16'd1);
      new_err   = op_bad
                | (busy & (op_awr | op_start | op_brd | op_cfg))
                | (idle & op_cfg & cfg_bad)
                | (idle & op_awr & awr_oob)
                | (idle & op_brd & brd_oob_c);
      a_we  = idle & op_awr & ~awr_oob;
      b_we  = busy & ~fin & ~op_abort;
      a_idx = AW'(32'(hi) * 32'(MAX_N) + 32'(lo));
      e_a   = AW'(32'(ci) * 32'(MAX_N) + 32'(cj));
      e_b   = md ? BW'(32'(ci) * 32'(BD) + 32'(cj))
                 : BW'(32'(cj) * 32'(BD) + 32'(ci));
      r_idx = BW'(32'(hi) * 32'(BD) + 32'(lo));
   end

   always_ff @(posedge clk) begin
      if (a_we) a_mem[a_idx] <= rs2_val[DATA_W-1:0];
      if (b_we) b_mem[e_b] <= a_mem[e_a];
      if (idle & op_brd & ~brd_oob_c) bq <= b_mem[r_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         rdy      <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         fin      <= 1'b0;
         md       <= 1'b0;
         rows     <= RMAX;
         cols     <= CMAX;
         ci       <= 16'd0;
         cj       <= 16'd0;
         brd_p1   <= 1'b0;
         brd_oob  <= 1'b0;
         rd_we    <= 1'b0;
         rd_waddr <= 5'd0;
         rd_wdata <= 32'd0;
      end else begin
         // one response in flight: stall issue until its writeback
         rdy    <= ~(op_stat | (idle & op_brd)) & ~brd_p1;
         err    <= (err & ~op_stat) | new_err;
         brd_p1 <= idle & op_brd;
         rd_we  <= 1'b0;
         if (op_stat) begin
            rd_we    <= 1'b1;
            rd_waddr <= rd_addr;
            rd_wdata <= {29'd0, err, busy, done};
         end
         if (idle & op_brd) begin
            rd_waddr <= rd_addr;
            brd_oob  <= brd_oob_c;
         end
         if (brd_p1) begin
            rd_we    <= 1'b1;
            rd_wdata <= brd_oob ? 32'd0 : 32'(bq);
         end
         unique case (state)
            IDLE: begin
               if (op_cfg | op_awr) done <= 1'b0;
               if (op_cfg & ~cfg_bad) begin
                  rows <= hi;
                  cols <= lo;
                  md   <= rs2_val[0];
               end
               if (op_start) begin
                  state <= BUSY;
                  done  <= 1'b0;
                  fin   <= 1'b0;
                  ci    <= 16'd0;
                  cj    <= 16'd0;
               end
            end
            BUSY: begin
               if (op_abort) state <= IDLE;
               else if (fin) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end else if (last) fin <= 1'b1;
               else if (cj == cols - 16'd1) begin
                  cj <= 16'd0;
                  ci <= ci + 16'd1;
               end else cj <= cj + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign instr_ready = rdy;
   assign accel_busy  = busy;
   assign accel_done  = done;
   assign accel_err   = err;
endmodule

// File: tb/tb_transpose_rtype_cfg.sv
// Scoreboard bench for transpose_rtype_cfg: random matrices checked
// against a transaction-level model of A, B, config and status.
module tb_transpose_rtype_cfg;
   localparam int MM = 8;
   localparam int MN = 8;
   localparam int BD = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0, rs1_val = '0, rs2_val = '0;
   logic [4:0]  rd_addr = '0;
   logic        rd_we;
   logic [4:0]  rd_waddr;
   logic [31:0] rd_wdata;
   logic        accel_busy, accel_done, accel_err;

   always #5 clk = ~clk;

   transpose_rtype_cfg #(.MAX_M(MM), .MAX_N(MN), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .rd_addr(rd_addr), .rd_we(rd_we), .rd_waddr(rd_waddr),
      .rd_wdata(rd_wdata), .accel_busy(accel_busy),
      .accel_done(accel_done), .accel_err(accel_err)
   );

   typedef struct {
      logic [31:0] data;
      logic [4:0]  addr;
      int          at;
   } exp_t;

   exp_t        sbq[$];
   int          n_chk = 0, n_fail = 0, cyc = 0, n_we = 0;
   logic [31:0] mA [MM][MN];
   logic [31:0] mB [BD][BD];
   int          mR = MM, mC = MN;
   bit          mMD = 0, mErr = 0, mDone = 0, mBusy = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (rst_n && rd_we) begin
         exp_t e;
         n_we++;
         if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rd_we: got data %h required no write",
                     rd_wdata);
         end else begin
            e = sbq.pop_front();
            check("rd_wdata", rd_wdata, e.data);
            check("rd_waddr", 32'(rd_waddr), 32'(e.addr));
            check("rd_we_cycle", cyc, e.at);
         end
      end
   end

   task automatic send(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int at);
      int k = 0;
      @(negedge clk);
      while (!instr_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!instr_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL ready_timeout: instr_ready 0 required 1");
      end
      instr       = {f7, 10'd0, f3, 5'd0, 7'h33};
      rs1_val     = a;
      rs2_val     = b;
      rd_addr     = rd;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      at = cyc;
   endtask

   task automatic op_stat();
      int at;
      logic [4:0] rd = 5'($urandom_range(0, 31));
      logic [31:0] e = {29'd0, mErr, mBusy, mDone};
      send(7'h02, 3'd2, 0, 0, rd, at);
      sbq.push_back('{e, rd, at});
      mErr = 0;
   endtask

   task automatic op_brd(input int r, input int c);
      int at;
      logic [4:0] rd = 5'($urandom_range(0, 31));
      bit inb = mMD ? (r < mR && c < mC) : (r < mC && c < mR);
      logic [31:0] e = inb ? mB[r][c] : 32'd0;
      if (!inb) mErr = 1;
      send(7'h02, 3'd3, {16'(r), 16'(c)}, 0, rd, at);
      sbq.push_back('{e, rd, at + 1});
   endtask

   task automatic op_awr(input int r, input int c, input logic [31:0] v);
      int at;
      if (mBusy) mErr = 1;
      else begin
         mDone = 0;
         if (r < mR && c < mC) mA[r][c] = v;
         else mErr = 1;
      end
      send(7'h02, 3'd0, {16'(r), 16'(c)}, v, 0, at);
   endtask

   task automatic op_cfg(input int r, input int c, input bit md);
      int at;
      mDone = 0;
      if (r == 0 || c == 0 || r > MM || c > MN) mErr = 1;
      else begin
         mR = r;
         mC = c;
         mMD = md;
      end
      send(7'h02, 3'd4, {16'(r), 16'(c)}, {31'd0, md}, 0, at);
   endtask

   task automatic op_abort();
      int at;
      send(7'h02, 3'd5, 0, 0, 0, at);
      mBusy = 0;
      mDone = 0;
   endtask

   task automatic op_start();
      int at;
      send(7'h02, 3'd1, 0, 0, 0, at);
      mBusy = 1;
      mDone = 0;
   endtask

   task automatic start_wait();
      int n = 0;
      op_start();
      while (n < 2000) begin
         @(posedge clk);
         #1;
         n++;
         if (accel_done) break;
      end
      check("start_to_done", n, mR * mC + 1);
      check("busy_after_done", 32'(accel_busy), 0);
      for (int i = 0; i < mR; i++)
         for (int j = 0; j < mC; j++)
            if (mMD) mB[i][j] = mA[i][j];
            else mB[j][i] = mA[i][j];
      mBusy = 0;
      mDone = 1;
   endtask

   task automatic fill_rand();
      for (int r = 0; r < mR; r++)
         for (int c = 0; c < mC; c++) op_awr(r, c, $urandom);
   endtask

   task automatic check_reset_outs(input string nm);
      check({nm, "_rd_we"}, 32'(rd_we), 0);
      check({nm, "_rd_wdata"}, rd_wdata, 0);
      check({nm, "_rd_waddr"}, 32'(rd_waddr), 0);
      check({nm, "_ready"}, 32'(instr_ready), 0);
      check({nm, "_status"}, {accel_err, accel_busy, accel_done}, 0);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running");
      $fatal(1);
   end

   initial begin
      int at, we0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", 32'(instr_ready), 1);

      // default 8x8 transpose of the reference pattern
      for (int r = 0; r < MM; r++)
         for (int c = 0; c < MN; c++)
            op_awr(r, c, 32'h3F80_0000 + (r << 8) + c);
      start_wait();
      for (int r = 0; r < MN; r++)
         for (int c = 0; c < MM; c++) op_brd(r, c);

      // 3x5 transpose, out-of-range reads and writes, ready timing
      op_cfg(3, 5, 0);
      fill_rand();
      start_wait();
      op_brd(4, 2);
      check("brd_ready_t1", 32'(instr_ready), 0);
      settle(1);
      check("brd_ready_t2", 32'(instr_ready), 0);
      settle(1);
      check("brd_ready_t3", 32'(instr_ready), 1);
      op_brd(0, 3);
      op_stat();
      check("stat_ready_t1", 32'(instr_ready), 0);
      settle(1);
      check("stat_ready_t2", 32'(instr_ready), 1);
      op_stat();
      op_awr(3, 0, 32'h1234_5678);
      op_stat();
      op_stat();

      // 4x4 copy mode
      op_cfg(4, 4, 1);
      fill_rand();
      start_wait();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) op_brd(r, c);

      // commands while busy, then abort
      op_cfg(8, 8, 0);
      op_start();
      op_awr(0, 0, 32'hDEAD_BEEF);
      op_stat();
      op_abort();
      op_stat();
      start_wait();
      op_brd(0, 0);
      op_brd(7, 7);

      // illegal configs keep 8x8; illegal funct7 has no writeback
      op_cfg(0, 4, 0);
      op_cfg(8, MN + 1, 1);
      op_stat();
      start_wait();
      op_brd(3, 5);
      settle(3);
      we0 = n_we;
      send(7'h01, 3'd2, 0, 0, 5'd7, at);
      mErr = 1;
      settle(4);
      check("illegal_no_rd_we", n_we, we0);
      op_stat();

      // randomized shapes and modes
      for (int it = 0; it < 5; it++) begin
         op_cfg($urandom_range(1, MM), $urandom_range(1, MN),
                1'($urandom_range(0, 1)));
         fill_rand();
         start_wait();
         for (int k = 0; k < 10; k++)
            op_brd($urandom_range(0, 9), $urandom_range(0, 9));
         op_stat();
      end

      // reset in the middle of an operation
      op_cfg(6, 7, 1);
      op_start();
      settle(10);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      mR = MM;
      mC = MN;
      mMD = 0;
      mErr = 0;
      mDone = 0;
      mBusy = 0;
      @(posedge clk);
      #1;
      check("ready_after_midreset", 32'(instr_ready), 1);
      op_stat();
      start_wait();
      op_brd(6, 1);

      settle(6);
      check("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
